// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host controller: register map, STATUS/CTRL/IE
// bit positions, TX engine states and a constant-evaluable clog2 helper.
package uart_host_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_IE     = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_BUSY  = 2;
    localparam int ST_RX_VALID = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_AVAIL    = 6;
    localparam int ST_RX_BIT8  = 7;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_BITS     = 1;
    localparam int CTRL_PARITY   = 2;
    localparam int CTRL_RATE_LSB = 4;

    localparam int IE_RX = 0;
    localparam int IE_TX = 1;

    localparam int RX_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head combinationally.
// Push when full is dropped unless a pop in the same cycle frees the slot.
module uart_host_fifo
    import uart_host_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// CPU-side controller for the uart block: 4-register byte bus, TX FIFO + write handshake, RX capture, one irq.
// bus_rdata and irq are registered (1 cycle); TX bytes beyond a full FIFO are dropped. UART_HOST_RXFIFO_EN adds an RX FIFO.
module uart_host_ctrl
    import uart_host_pkg::*;
#(
    parameter int TX_DEPTH    = 4,
    parameter int HOLD_CYC    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_CPU,
    input  logic       RST,
    input  logic [1:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic       uart_en,
    output logic       uart_bits,
    output logic       uart_parity,
    output logic [3:0] uart_bitrate,
    output logic       UART_WRITE,
    output logic [7:0] DATA_IN_Tx,
    input  logic       IRQ_Tx,
    input  logic       IRQ_Rx,
    input  logic       UART_AVAIL,
    input  logic [9:0] DATA_OUT_Rx
);

    localparam int CNT_W = clog2(HOLD_CYC + 1);

    logic [7:0] ctrl_q;
    logic [7:0] ie_q;
    logic [7:0] rdata_q;
    logic [7:0] status;
    logic       tx_ovf_q;
    logic       rx_ovr_q;
    logic       irq_q;

    logic       wr_data, wr_status, wr_ctrl, wr_ie, rd_data;

    logic [SYNC_STAGES-1:0] tx_sync, rx_sync, avail_sync;
    logic       tx_prev, rx_prev;
    logic       tx_done, rx_done;

    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;

    tx_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic       uart_write_q;
    logic [7:0] tx_byte_q;
    logic       tx_start, tx_busy;

    logic       rx_valid;
    logic [9:0] rx_word;
    logic       rx_ovr_set;

    assign wr_data   = bus_wr && (bus_addr == ADDR_DATA);
    assign wr_status = bus_wr && (bus_addr == ADDR_STATUS);
    assign wr_ctrl   = bus_wr && (bus_addr == ADDR_CTRL);
    assign wr_ie     = bus_wr && (bus_addr == ADDR_IE);
    assign rd_data   = bus_rd && (bus_addr == ADDR_DATA);

    assign uart_en      = ctrl_q[CTRL_EN];
    assign uart_bits    = ctrl_q[CTRL_BITS];
    assign uart_parity  = ctrl_q[CTRL_PARITY];
    assign uart_bitrate = ctrl_q[CTRL_RATE_LSB +: 4];
    assign UART_WRITE   = uart_write_q;
    assign DATA_IN_Tx   = tx_byte_q;
    assign bus_rdata    = rdata_q;
    assign irq          = irq_q;

    // IRQ_Tx / IRQ_Rx come from the uart clock domain; only synchronised edges are used.
    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) begin
            tx_sync    <= '0;
            rx_sync    <= '0;
            avail_sync <= '0;
            tx_prev    <= 1'b0;
            rx_prev    <= 1'b0;
        end else begin
            tx_sync    <= {tx_sync[SYNC_STAGES-2:0], IRQ_Tx};
            rx_sync    <= {rx_sync[SYNC_STAGES-2:0], IRQ_Rx};
            avail_sync <= {avail_sync[SYNC_STAGES-2:0], UART_AVAIL};
            tx_prev    <= tx_sync[SYNC_STAGES-1];
            rx_prev    <= rx_sync[SYNC_STAGES-1];
        end
    end

    assign tx_done = tx_sync[SYNC_STAGES-1] && !tx_prev;
    assign rx_done = rx_sync[SYNC_STAGES-1] && !rx_prev;

    uart_host_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_CPU),
        .rst_n (RST),
        .push  (wr_data),
        .pop   (tx_pop),
        .din   (bus_wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!tx_empty && uart_en) state_nxt = LOAD;
            LOAD: begin
                if (!uart_en)        state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = WAIT;
            end
            WAIT: if (!uart_en || tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state == IDLE) && (state_nxt == LOAD);
        tx_busy  = (state != IDLE);
        tx_pop   = tx_start;
    end

    // UART_WRITE tracks the registered LOAD state so it is glitch-free toward the uart.
    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) begin
            cnt          <= '0;
            tx_byte_q    <= '0;
            uart_write_q <= 1'b0;
        end else begin
            uart_write_q <= (state_nxt == LOAD);
            if (tx_start) begin
                cnt       <= CNT_W'(HOLD_CYC - 1);
                tx_byte_q <= tx_head;
            end else if (state == LOAD && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef UART_HOST_RXFIFO_EN
    logic rx_full, rx_empty;

    uart_host_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_CPU),
        .rst_n (RST),
        .push  (rx_done),
        .pop   (rd_data),
        .din   (DATA_OUT_Rx),
        .dout  (rx_word),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_valid   = !rx_empty;
    assign rx_ovr_set = rx_done && rx_full && !rd_data;
`else
    logic [9:0] rx_data_q;
    logic       rx_valid_q;

    // A DATA read in the same cycle as rx_done empties the holder first, so no overrun.
    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_done && (!rx_valid_q || rd_data)) begin
            rx_data_q  <= DATA_OUT_Rx;
            rx_valid_q <= 1'b1;
        end else if (rd_data) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_word    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_ovr_set = rx_done && rx_valid_q && !rd_data;
`endif

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_BUSY]  = tx_busy;
        status[ST_RX_VALID] = rx_valid;
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_AVAIL]    = avail_sync[SYNC_STAGES-1];
        status[ST_RX_BIT8]  = rx_word[8];
    end

    // Sticky flags: a new event in the clearing cycle wins over the write-1-to-clear.
    always_ff @(posedge clk_CPU or negedge RST) begin
        if (!RST) begin
            ctrl_q   <= '0;
            ie_q     <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= bus_wdata;
            if (wr_ie)   ie_q   <= bus_wdata;

            if (wr_data && tx_full && !tx_pop)          tx_ovf_q <= 1'b1;
            else if (wr_status && bus_wdata[ST_TX_OVF]) tx_ovf_q <= 1'b0;

            if (rx_ovr_set)                             rx_ovr_q <= 1'b1;
            else if (wr_status && bus_wdata[ST_RX_OVR]) rx_ovr_q <= 1'b0;

            if (bus_rd) begin
                case (bus_addr)
                    ADDR_DATA:   rdata_q <= rx_word[7:0];
                    ADDR_STATUS: rdata_q <= status;
                    ADDR_CTRL:   rdata_q <= ctrl_q;
                    default:     rdata_q <= ie_q;
                endcase
            end

            irq_q <= (rx_valid && ie_q[IE_RX]) || (tx_empty && !tx_busy && ie_q[IE_TX]);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rx_word[9], ctrl_q[3], ie_q[7:2]};

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl: transaction-level model of FIFO/flags plus a per-cycle transmit monitor.
module tb_uart_host_ctrl;

    localparam int HOLD = 16;
    localparam int TXD  = 4;
    localparam int SS   = 2;

    logic       clk_CPU;
    logic       RST;
    logic [1:0] bus_addr;
    logic       bus_wr, bus_rd;
    logic [7:0] bus_wdata, bus_rdata;
    logic       irq, uart_en, uart_bits, uart_parity;
    logic [3:0] uart_bitrate;
    logic       UART_WRITE;
    logic [7:0] DATA_IN_Tx;
    logic       IRQ_Tx, IRQ_Rx, UART_AVAIL;
    logic [9:0] DATA_OUT_Rx;

    uart_host_ctrl #(.TX_DEPTH(TXD), .HOLD_CYC(HOLD), .SYNC_STAGES(SS)) dut (
        .clk_CPU(clk_CPU), .RST(RST), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq), .uart_en(uart_en),
        .uart_bits(uart_bits), .uart_parity(uart_parity), .uart_bitrate(uart_bitrate),
        .UART_WRITE(UART_WRITE), .DATA_IN_Tx(DATA_IN_Tx), .IRQ_Tx(IRQ_Tx), .IRQ_Rx(IRQ_Rx),
        .UART_AVAIL(UART_AVAIL), .DATA_OUT_Rx(DATA_OUT_Rx)
    );

    initial begin
        clk_CPU = 1'b0;
        forever #5 clk_CPU = ~clk_CPU;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, kept at register/queue level.
    logic [7:0] m_txq[$];
    logic [7:0] m_ctrl, m_ie;
    logic       m_ovf, m_ovr, m_rx_valid, m_avail;
    logic [9:0] m_rx_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_ctrl = 8'h00; m_ie = 8'h00;
        m_ovf = 1'b0; m_ovr = 1'b0; m_rx_valid = 1'b0;
        m_rx_data = 10'h000;
    endtask

    function automatic logic [7:0] exp_status(input logic busy);
        return {m_rx_data[8], m_avail, m_ovf, m_ovr, m_rx_valid, busy,
                (m_txq.size() == 0), (m_txq.size() == TXD)};
    endfunction

    function automatic logic exp_irq(input logic busy);
        return (m_rx_valid & m_ie[0]) | ((m_txq.size() == 0) & ~busy & m_ie[1]);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        case (a)
            2'd0: if (m_txq.size() < TXD) m_txq.push_back(d); else m_ovf = 1'b1;
            2'd1: begin
                if (d[4]) m_ovr = 1'b0;
                if (d[5]) m_ovf = 1'b0;
            end
            2'd2: m_ctrl = d;
            default: m_ie = d;
        endcase
        @(negedge clk_CPU);
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_addr = a; bus_rd = 1'b1;
        @(negedge clk_CPU);
        bus_rd = 1'b0;
        d = bus_rdata;
        if (a == 2'd0) m_rx_valid = 1'b0;
    endtask

    task automatic pulse_tx();
        IRQ_Tx = 1'b1;
        repeat (4) @(negedge clk_CPU);
        IRQ_Tx = 1'b0;
        repeat (3) @(negedge clk_CPU);
    endtask

    task automatic pulse_rx(input logic [9:0] w);
        DATA_OUT_Rx = w; IRQ_Rx = 1'b1;
        repeat (4) @(negedge clk_CPU);
        IRQ_Rx = 1'b0;
        repeat (3) @(negedge clk_CPU);
        if (!m_rx_valid) begin
            m_rx_data = w; m_rx_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic wait_uw(input logic v, input string nm);
        int n;
        n = 0;
        while (UART_WRITE !== v && n < 300) begin
            @(negedge clk_CPU);
            n++;
        end
        chk(nm, UART_WRITE, v);
    endtask

    // Transmit monitor: each UART_WRITE burst must carry the next queued byte for HOLD cycles.
    logic [7:0] mon_byte;
    int         mon_len;
    logic       mon_prev;
    initial begin
        mon_byte = 8'h00; mon_len = 0; mon_prev = 1'b0;
        forever begin
            @(posedge clk_CPU);
            #1;
            if (!RST) begin
                mon_prev = 1'b0;
                mon_len  = 0;
            end else begin
                chk("cfg_outputs", {uart_bitrate, uart_parity, uart_bits, uart_en},
                    {m_ctrl[7:4], m_ctrl[2:0]});
                if (UART_WRITE && !mon_prev) begin
                    mon_len = 0;
                    if (m_txq.size() == 0) begin
                        n_checks++;
                        mon_byte = DATA_IN_Tx;
                        $display("FAIL tx_spurious_start: got byte %0h sent, expected no transmission", DATA_IN_Tx);
                    end else begin
                        mon_byte = m_txq.pop_front();
                        chk("tx_byte", DATA_IN_Tx, mon_byte);
                    end
                end
                if (UART_WRITE) mon_len++;
                if (!UART_WRITE && mon_prev) begin
                    chk("tx_hold_cycles", mon_len, HOLD);
                    chk("tx_byte_held", DATA_IN_Tx, mon_byte);
                end
                mon_prev = UART_WRITE;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    logic [7:0] rd;

    initial begin
        RST = 1'b1; bus_addr = 2'd0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = 8'h00;
        IRQ_Tx = 1'b0; IRQ_Rx = 1'b0; UART_AVAIL = 1'b0; DATA_OUT_Rx = 10'h000;
        m_avail = 1'b0;
        model_reset();
        #3 RST = 1'b0;
        repeat (3) @(negedge clk_CPU);
        RST = 1'b1;

        // 1: reset state
        repeat (2) @(negedge clk_CPU);
        chk("reset_irq", irq, 1'b0);
        chk("reset_uart_write", UART_WRITE, 1'b0);
        bus_read(2'd1, rd);
        chk("reset_status", rd, 8'h02);
        UART_AVAIL = 1'b1; m_avail = 1'b1;
        repeat (4) @(negedge clk_CPU);
        bus_read(2'd1, rd);
        chk("status_avail", rd, 8'h42);
        UART_AVAIL = 1'b0; m_avail = 1'b0;
        repeat (4) @(negedge clk_CPU);

        // 2: single byte transmit and busy/idle timing
        bus_write(2'd2, 8'h91);
        bus_write(2'd0, 8'hA5);
        wait_uw(1'b1, "tx1_start");
        chk("tx1_data", DATA_IN_Tx, 8'hA5);
        wait_uw(1'b0, "tx1_end");
        bus_read(2'd1, rd);
        chk("tx1_status_wait", rd, exp_status(1'b1));
        IRQ_Tx = 1'b1;
        bus_read(2'd1, rd);
        chk("tx1_busy_after_edge", rd, 8'h06);
        repeat (3) @(negedge clk_CPU);
        bus_read(2'd1, rd);
        chk("tx1_idle", rd, exp_status(1'b0));
        IRQ_Tx = 1'b0;
        repeat (3) @(negedge clk_CPU);
        bus_write(2'd3, 8'h02);
        @(negedge clk_CPU);
        chk("irq_tx_idle", irq, exp_irq(1'b0));
        bus_write(2'd3, 8'h00);
        @(negedge clk_CPU);
        chk("irq_tx_idle_off", irq, exp_irq(1'b0));

        // 3: overflow with EN=0, then drain in order
        bus_write(2'd2, 8'h90);
        for (int i = 1; i <= 5; i++) bus_write(2'd0, 8'(i));
        bus_read(2'd1, rd);
        chk("full_ovf_status", rd, exp_status(1'b0));
        chk("full_ovf_literal", rd, 8'h21);
        bus_write(2'd1, 8'h20);
        bus_read(2'd1, rd);
        chk("ovf_cleared", rd, 8'h01);
        bus_write(2'd2, 8'h91);
        for (int i = 0; i < 4; i++) begin
            wait_uw(1'b1, "drain_start");
            wait_uw(1'b0, "drain_end");
            pulse_tx();
        end
        bus_read(2'd1, rd);
        chk("drained_status", rd, exp_status(1'b0));

        // 4: RX capture and interrupt
        bus_write(2'd3, 8'h01);
        pulse_rx(10'h15A);
        chk("irq_rx", irq, exp_irq(1'b0));
        chk("irq_rx_literal", irq, 1'b1);
        bus_read(2'd1, rd);
        chk("rx_status", rd, 8'h8A);
        bus_read(2'd0, rd);
        chk("rx_data", rd, 8'h5A);
        repeat (2) @(negedge clk_CPU);
        chk("irq_rx_cleared", irq, exp_irq(1'b0));
        bus_read(2'd1, rd);
        chk("rx_status_after_read", rd, exp_status(1'b0));

        // 5: overrun, then read coinciding with rx_done
        pulse_rx(10'h033);
        pulse_rx(10'h044);
        bus_read(2'd0, rd);
        chk("ovr_data_kept_first", rd, 8'h33);
        bus_read(2'd1, rd);
        chk("ovr_status", rd, 8'h12);
        chk("ovr_status_model", rd, exp_status(1'b0));
        bus_write(2'd1, 8'h10);
        pulse_rx(10'h077);
        DATA_OUT_Rx = 10'h1C8; IRQ_Rx = 1'b1;
        repeat (2) @(negedge clk_CPU);
        bus_read(2'd0, rd);
        chk("coincide_old_word", rd, 8'h77);
        m_rx_data = 10'h1C8; m_rx_valid = 1'b1;
        repeat (2) @(negedge clk_CPU);
        IRQ_Rx = 1'b0;
        repeat (3) @(negedge clk_CPU);
        bus_read(2'd1, rd);
        chk("coincide_status", rd, exp_status(1'b0));
        chk("coincide_status_literal", rd, 8'h8A);
        bus_read(2'd0, rd);
        chk("coincide_new_word", rd, 8'hC8);

        // 6: asynchronous reset in the middle of LOAD
        bus_write(2'd0, 8'h3C);
        wait_uw(1'b1, "rst_tx_start");
        repeat (3) @(negedge clk_CPU);
        #2 RST = 1'b0;
        model_reset();
        #1 chk("uw_async_drop", UART_WRITE, 1'b0);
        @(negedge clk_CPU);
        RST = 1'b1;
        @(negedge clk_CPU);
        bus_read(2'd1, rd);
        chk("post_reset_status", rd, 8'h02);
        bus_write(2'd2, 8'h91);
        repeat (40) @(negedge clk_CPU);
        chk("post_reset_no_tx", UART_WRITE, 1'b0);
        bus_read(2'd1, rd);
        chk("post_reset_idle", rd, exp_status(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- CPU-side controller at the other end of the uart block's host interface: drives UART_WRITE / DATA_IN_Tx / configuration, and consumes IRQ_Tx, IRQ_Rx and DATA_OUT_Rx.
- Exposes a 4-register byte bus to the processor.
- Buffers outgoing bytes in a TX FIFO and sequences the transmit handshake.
- Captures received words and raises one combined interrupt.
- Runs entirely on clk_CPU.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- HOLD_CYC, 16, clk_CPU cycles UART_WRITE is held high; must cover at least one uart_clock period.
- SYNC_STAGES, 2, flops in each IRQ_Tx / IRQ_Rx synchroniser.

Ports:
- clk_CPU  in  1  processor clock; the single clock.
- RST  in  1  reset, asynchronous, active-low.
- bus_addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 IE.
- bus_wr  in  1  write strobe, one cycle.
- bus_rd  in  1  read strobe, one cycle.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  read data, registered.
- irq  out  1  combined interrupt, level.
- uart_en  out  1  drives uart EN (CTRL[0]).
- uart_bits  out  1  drives UART_BITS (CTRL[1]).
- uart_parity  out  1  drives UART_PARITY (CTRL[2]).
- uart_bitrate  out  4  drives bitrate (CTRL[7:4]).
- UART_WRITE  out  1  transmit request to the uart block.
- DATA_IN_Tx  out  8  byte to transmit; stable while UART_WRITE is high and through WAIT.
- IRQ_Tx  in  1  transmit-done from the uart block; asynchronous to clk_CPU.
- IRQ_Rx  in  1  receive-done from the uart block.
- UART_AVAIL  in  1  receiver data available; reflected in STATUS only.
- DATA_OUT_Rx  in  10  received word; stable while IRQ_Rx is high.

Behaviour:
- Reset (RST=0, asynchronous):
  - All registers, outputs and flags go to 0; FIFO is emptied; TX engine goes to IDLE.
  - UART_WRITE drops immediately.
  - STATUS then reads 0x02 (TX_EMPTY only).
- Bus writes:
  - DATA: push bus_wdata into the TX FIFO. If the FIFO is full, the byte is dropped and sticky TX_OVF is set.
  - STATUS: write-1-to-clear bits 4 and 5; all other bits are ignored.
  - CTRL, IE: plain registers.
- Bus reads:
  - bus_rdata is valid the cycle after bus_rd and holds until the next read.
  - DATA returns rx_data[7:0] and clears RX_VALID.
  - Reading DATA while RX_VALID=0 returns the last captured value.
- STATUS bits:
  - [0] TX_FULL
  - [1] TX_EMPTY
  - [2] TX_BUSY (engine not in IDLE)
  - [3] RX_VALID
  - [4] RX_OVR
  - [5] TX_OVF
  - [6] UART_AVAIL, synchronised
  - [7] rx_data[8]
- IE register and interrupt:
  - IE[0] enables the RX interrupt; IE[1] enables the TX-idle interrupt.
  - irq = (RX_VALID & IE[0]) | (TX_EMPTY & ~TX_BUSY & IE[1]), registered (one cycle latency).
- Synchronisers: IRQ_Tx and IRQ_Rx each pass through SYNC_STAGES flops, then a rising-edge detector (tx_done, rx_done pulses).
- TX engine states:
  - IDLE: if FIFO not empty and uart_en=1, pop the head into DATA_IN_Tx, assert UART_WRITE, load counter = HOLD_CYC-1, go to LOAD.
  - LOAD: decrement the counter. At 0, deassert UART_WRITE and go to WAIT.
  - WAIT: on tx_done, go to IDLE. The next byte may start on the following cycle.
  - uart_en=0 in LOAD or WAIT: go to IDLE next cycle and drop UART_WRITE; the in-flight byte is lost and FIFO contents are kept.
- TX FIFO:
  - Push and pop in the same cycle are both honoured, including when full (pop frees the slot first).
  - Pointers wrap modulo TX_DEPTH; count width is clog2(TX_DEPTH)+1.
- RX capture:
  - On rx_done, DATA_OUT_Rx is registered into rx_data[9:0] and RX_VALID is set.
  - If RX_VALID is already 1: the new word is dropped and sticky RX_OVR is set.
  - Exception: a same-cycle DATA read pops first, then the new word is stored with RX_VALID=1 and no overrun.

Optional Feature:
- Macro: UART_HOST_RXFIFO_EN.
- Defined:
  - Received words go into a 4-entry RX FIFO (second uart_host_fifo instance, width 10).
  - RX_VALID means RX FIFO not empty; DATA read pops the FIFO.
  - RX_OVR is set only when a word arrives and the FIFO is full.
  - STATUS[7] shows the head entry's bit 8.
- Undefined: single holding register, exactly as described in Behaviour.

Decomposition:
- Package uart_host_pkg holds:
  - Register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_IE=3).
  - STATUS and CTRL bit-index constants.
  - TX engine state enum (IDLE, LOAD, WAIT).
  - clog2 helper.
- One sub-module: uart_host_fifo.
  - Parameterised WIDTH/DEPTH synchronous FIFO.
  - Ports: push, pop, din, dout (first-word-fall-through), full, empty.
  - Used for TX, and for RX when the feature is enabled.

Test Plan:
1. Reset, then read STATUS -> 0x02; irq=0, UART_WRITE=0, all uart_* config outputs 0.
2. Write CTRL=0x91, then DATA=0xA5 -> UART_WRITE high exactly 16 cycles with DATA_IN_Tx=0xA5; TX_BUSY=1 until an IRQ_Tx rising edge; IDLE 3+SYNC_STAGES cycles after the edge.
3. With CTRL.EN=0, write DATA five times (0x01..0x05) into depth 4 -> TX_FULL=1, TX_OVF=1, FIFO holds 0x01..0x04. Write STATUS=0x20 -> TX_OVF=0. Set EN -> bytes 0x01..0x04 sent in order.
4. IE=0x01; pulse IRQ_Rx with DATA_OUT_Rx=0x15A -> RX_VALID=1, irq=1, STATUS[7]=1. Read DATA -> 0x5A, RX_VALID=0, irq=0.
5. Two IRQ_Rx pulses (0x033, then 0x044) with no read -> DATA reads 0x33, RX_OVR=1. A DATA read coinciding with rx_done -> new word kept, RX_OVR stays 0.
6. Assert RST mid-LOAD -> UART_WRITE=0 immediately; after release FIFO is empty, state IDLE, and no transmission occurs.
